chronologic: RTL and testbench
==============================

Name: chronologic

Overview:
- Round-robin request/grant arbiter for NUM_REQ masters sharing one resource.
- Once a request is selected, the grant is issued after a fixed, bounded latency of MIN_LAT cycles.
- The grant is then held until the master drops its request.
- Any requester left waiting longer than MAX_LAT cycles raises a sticky latency-error flag.
- Sits between bus masters and a shared slave or port.

Parameters:
- NUM_REQ, 2, number of requesting masters (1..8).
- MIN_LAT, 2, cycles from selection edge to the first edge where grant is sampled high (1 <= MIN_LAT <= MAX_LAT).
- MAX_LAT, 5, maximum allowed cycles from first sampled req to sampled grant before lat_err is set.
- CNT_W, $clog2(MAX_LAT+2), width of the wait and delay counters (derived, do not override).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-master request; level, held until served.
- grant  out  NUM_REQ  one-hot-or-zero grant, registered.
- busy  out  1  high whenever the FSM is not IDLE.
- lat_err  out  NUM_REQ  sticky per-master latency violation.
- err_clr  in  1  clears all lat_err bits (synchronous).

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - Applies at any edge where rst=1, including mid-operation.
  - grant=0, busy=0, lat_err=0, FSM=IDLE, RR pointer=0, all counters=0.
- FSM states: IDLE, DELAY, GRANT.
- IDLE:
  - At an edge with any req bit high, select the first requesting index at or after the pointer (wrap-around search).
  - Latch the selected index as sel and go to DELAY; delay counter=1.
  - No req: stay in IDLE.
- DELAY:
  - The counter increments each edge.
  - At the edge where the counter reaches MIN_LAT, register grant[sel]=1 and go to GRANT.
  - Externally, if selection occurs at edge Ts, grant is sampled high at edge Ts+MIN_LAT.
  - If req[sel] is sampled low during DELAY, abandon: no grant is issued, the pointer advances to sel+1, go to IDLE.
- GRANT:
  - grant[sel] stays high while req[sel] is sampled high.
  - At the edge where req[sel] is sampled low, grant drops to 0 (visible the same edge), the pointer becomes sel+1 mod NUM_REQ, go to IDLE.
  - There is always at least one IDLE cycle between grants.
- Grant legality:
  - grant is never high for an index whose req was low at the previous edge, except on the single cycle of release.
  - At most one grant bit is ever high.
- Wait counters, one per master:
  - Reset to 0 whenever req[i]=0 or grant[i]=1.
  - Otherwise increment, saturating at MAX_LAT+1.
  - The first edge with req[i] high counts as 1.
- lat_err[i]:
  - Set when wait[i] would exceed MAX_LAT, i.e. req[i] has been high for MAX_LAT+1 sampled edges without grant[i].
  - Sticky until err_clr or rst.
  - If err_clr and a new set event coincide, set wins.
- Simultaneous requests: the round-robin pointer decides which master is selected.
- Non-selected requesters keep waiting; arbitration does not guarantee them the MAX_LAT bound, which lat_err reports.
- Requests arriving while busy are not sampled for selection until IDLE.

Optional Feature:
- Macro: CHRONOLOGIC_SVA_EN.
- When defined, embedded concurrent assertions are compiled in:
  - $onehot0(grant).
  - A rising grant[i] implies req[i] was high on the previous edge.
  - For a master requesting alone from IDLE: a rising req[i] implies grant[i] within [MIN_LAT:MAX_LAT] cycles.
  - lat_err is never set when NUM_REQ=1.
  - Assertions are disabled during rst.
- When undefined, no assertions are compiled; the RTL is functionally identical.

Decomposition:
- Package chronologic_pkg: FSM state enum (IDLE, DELAY, GRANT) and a function for the round-robin next-index search.
- One natural sub-module, chronologic_wait_mon: a per-master wait counter plus lat_err flag, instantiated NUM_REQ times.

Test Plan:
- Single master (defaults): req[0] sampled high at edge 1 -> grant[0] sampled high at edge 3; held while req stays high; req low at edge 6 -> grant low at edge 6; lat_err=0.
- Simultaneous req=2'b11 from reset -> grant=01 first; after req[0] drops, grant=10 follows; lat_err[1] set if its wait exceeds 5 (set exactly at the 6th ungranted edge).
- Abandon: req[0] high for 1 cycle only -> no grant; pointer advances to 1; busy returns to 0.
- Reset mid-GRANT: rst=1 at an edge while grant=01 -> grant=0, busy=0, lat_err=0 at that edge; arbitration restarts from index 0.
- err_clr after a forced lat_err -> bit clears next edge; err_clr coincident with a new violation -> bit stays set.
- MIN_LAT=5, MAX_LAT=5, single master -> grant sampled at edge Ts+5; no lat_err.

Source files
------------

// File: rtl/chronologic_pkg.sv
// Shared types and helpers for the chronologic round-robin arbiter.
package chronologic_pkg;

  // Width of the generic request vector handled by rr_pick.
  localparam int unsigned MaxReq = 8;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StGrant
  } state_e;

  // First requesting index at or after ptr, wrapping within n masters.
  // The result is only meaningful when at least one of req[n-1:0] is high.
  function automatic logic [2:0] rr_pick(input logic [MaxReq-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int unsigned       n);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MaxReq; k++) begin
      if (k < n) begin
        idx = 32'(ptr) + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[2:0]]) begin
          found = 1'b1;
          pick  = idx[2:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/chronologic_wait_mon.sv
// Per-master wait counter with a sticky latency-error flag.
module chronologic_wait_mon #(
  parameter int unsigned MAX_LAT = 5,
  parameter int unsigned CNT_W   = $clog2(MAX_LAT + 2)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic grant_i,
  input  logic err_clr_i,
  output logic lat_err_o
);

  logic [CNT_W-1:0] wait_q, wait_d;
  logic             lat_err_q, lat_err_d;
  logic             set_err;

  // Count ungranted request edges, saturating at MAX_LAT+1; set beats clear.
  always_comb begin
    wait_d    = wait_q;
    set_err   = req_i && !grant_i && (32'(wait_q) >= MAX_LAT);
    lat_err_d = lat_err_q;
    if (!req_i || grant_i) begin
      wait_d = '0;
    end else if (32'(wait_q) < MAX_LAT + 1) begin
      wait_d = wait_q + 1'b1;
    end
    if (set_err) begin
      lat_err_d = 1'b1;
    end else if (err_clr_i) begin
      lat_err_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_q    <= '0;
      lat_err_q <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      lat_err_q <= lat_err_d;
    end
  end

  assign lat_err_o = lat_err_q;

endmodule

// File: rtl/chronologic.sv
// Round-robin arbiter with fixed grant latency and per-master latency monitors.
// Optional embedded assertions are compiled when CHRONOLOGIC_SVA_EN is defined.
module chronologic
  import chronologic_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned MIN_LAT = 2,
  parameter int unsigned MAX_LAT = 5,
  parameter int unsigned CNT_W   = $clog2(MAX_LAT + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic [NUM_REQ-1:0] lat_err,
  input  logic               err_clr
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    sel_q, sel_d, ptr_q, ptr_d;
  logic [IdxW-1:0]    pick, sel_inc;
  logic [CNT_W-1:0]   dly_q, dly_d, dly_inc;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [MaxReq-1:0]  req_ext;

  // Candidate selection and helper increments.
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    pick                   = IdxW'(rr_pick(req_ext, 3'(ptr_q), NUM_REQ));
    sel_inc                = (32'(sel_q) == NUM_REQ - 1) ? '0 : sel_q + 1'b1;
    dly_inc                = dly_q + 1'b1;
  end

  // FSM next-state: select, wait MIN_LAT edges, hold until release.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    dly_d   = dly_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        grant_d = '0;
        if (|req) begin
          sel_d = pick;
          dly_d = CNT_W'(1);
          if (MIN_LAT == 1) begin
            grant_d[pick] = 1'b1;
            state_d       = StGrant;
          end else begin
            state_d = StDelay;
          end
        end
      end
      StDelay: begin
        if (!req[sel_q]) begin
          // Requester gave up before the grant: skip past it.
          ptr_d   = sel_inc;
          dly_d   = '0;
          state_d = StIdle;
        end else begin
          dly_d = dly_inc;
          if (32'(dly_inc) == MIN_LAT) begin
            grant_d[sel_q] = 1'b1;
            state_d        = StGrant;
          end
        end
      end
      StGrant: begin
        if (!req[sel_q]) begin
          grant_d = '0;
          ptr_d   = sel_inc;
          dly_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
  end

  // FSM and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      ptr_q   <= '0;
      dly_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      dly_q   <= dly_d;
      grant_q <= grant_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != StIdle);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_wait_mon
    chronologic_wait_mon #(
      .MAX_LAT(MAX_LAT),
      .CNT_W  (CNT_W)
    ) u_wait_mon (
      .clk_i    (clk),
      .rst_i    (rst),
      .req_i    (req[i]),
      .grant_i  (grant_q[i]),
      .err_clr_i(err_clr),
      .lat_err_o(lat_err[i])
    );
  end

`ifdef CHRONOLOGIC_SVA_EN
  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_sva
    a_grant_has_req: assert property (@(posedge clk) disable iff (rst)
      $rose(grant_q[g]) |-> $past(req[g]));
    a_lone_latency: assert property (@(posedge clk) disable iff (rst)
      (state_q == StIdle && $rose(req[g]) && req == (NUM_REQ'(1) << g))
        |-> ##[MIN_LAT:MAX_LAT] (grant_q[g] || !req[g]));
  end

  if (NUM_REQ == 1) begin : g_sva_single
    a_no_err: assert property (@(posedge clk) disable iff (rst) lat_err == '0);
  end
`endif

endmodule

// File: tb/tb_chronologic.sv
// Directed self-checking bench for chronologic: default build plus a
// MIN_LAT=MAX_LAT=5 single-master instance.
module tb_chronologic;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       err_clr = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] grant;
  logic       busy;
  logic [1:0] lat_err;
  logic [0:0] req5 = 1'b0;
  logic [0:0] grant5;
  logic       busy5;
  logic [0:0] lat5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  chronologic #(.NUM_REQ(2), .MIN_LAT(2), .MAX_LAT(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .grant  (grant),
    .busy   (busy),
    .lat_err(lat_err),
    .err_clr(err_clr)
  );

  chronologic #(.NUM_REQ(1), .MIN_LAT(5), .MAX_LAT(5)) dut5 (
    .clk    (clk),
    .rst    (rst),
    .req    (req5),
    .grant  (grant5),
    .busy   (busy5),
    .lat_err(lat5),
    .err_clr(err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; req5 = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; req5 = 1'b1;
    tick(); tick();
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got %b want 00", grant); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (lat_err !== 2'b00) begin n_fail++; $display("FAIL reset_laterr got %b want 00", lat_err); end
    n_tests++; if (grant5 !== 1'b0 || busy5 !== 1'b0) begin n_fail++; $display("FAIL reset_dut5 got g=%b b=%b want 0 0", grant5, busy5); end
    rst = 1'b0; req = 2'b00; req5 = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 2'b01;
    tick(); // e1: selection
    n_tests++; if (busy !== 1'b1 || grant !== 2'b00) begin n_fail++; $display("FAIL single_e1 got b=%b g=%b want 1 00", busy, grant); end
    tick(); // e2: grant registered, sampled high at e3
    n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_e2_grant got %b want 01", grant); end
    tick(); tick(); tick(); // e3..e5
    n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_hold got %b want 01", grant); end
    n_tests++; if (lat_err !== 2'b00) begin n_fail++; $display("FAIL single_laterr got %b want 00", lat_err); end
    req = 2'b00;
    tick(); // e6: release
    n_tests++; if (grant !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL single_release got g=%b b=%b want 00 0", grant, busy); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 2'b11;
    tick(); tick(); // e2
    n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL simul_first got %b want 01", grant); end
    tick(); tick(); tick(); // e5
    n_tests++; if (lat_err !== 2'b00) begin n_fail++; $display("FAIL simul_e5_laterr got %b want 00", lat_err); end
    tick(); // e6: sixth ungranted edge for master 1
    n_tests++; if (lat_err !== 2'b10) begin n_fail++; $display("FAIL simul_e6_laterr got %b want 10", lat_err); end
    req = 2'b10;
    tick(); // e7: release master 0
    n_tests++; if (grant !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL simul_gap got g=%b b=%b want 00 0", grant, busy); end
    tick(); // e8: select master 1
    n_tests++; if (busy !== 1'b1 || grant !== 2'b00) begin n_fail++; $display("FAIL simul_e8 got b=%b g=%b want 1 00", busy, grant); end
    tick(); // e9
    n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL simul_second got %b want 10", grant); end
    n_tests++; if (lat_err !== 2'b10) begin n_fail++; $display("FAIL simul_sticky got %b want 10", lat_err); end
    req = 2'b00;
    tick();
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL simul_release got %b want 00", grant); end
  endtask

  task automatic test_abandon();
    do_reset();
    req = 2'b01;
    tick(); // e1
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abandon_busy got %b want 1", busy); end
    req = 2'b00;
    tick(); // e2: abandon
    n_tests++; if (busy !== 1'b0 || grant !== 2'b00) begin n_fail++; $display("FAIL abandon_idle got b=%b g=%b want 0 00", busy, grant); end
    tick();
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL abandon_nogrant got %b want 00", grant); end
    req = 2'b11;
    tick(); tick(); // pointer now 1
    n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL abandon_ptr got %b want 10", grant); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b01; tick();   // e1
    req = 2'b00; tick();   // e2: abandon, pointer 1
    req = 2'b11; tick();   // e3: select 1
    tick();                // e4
    n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL rstmid_grant got %b want 10", grant); end
    tick(); tick(); tick(); tick(); // e8: master 0 waited six edges
    n_tests++; if (lat_err !== 2'b01) begin n_fail++; $display("FAIL rstmid_laterr got %b want 01", lat_err); end
    rst = 1'b1;
    tick();
    n_tests++; if (grant !== 2'b00 || busy !== 1'b0 || lat_err !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_clear got g=%b b=%b e=%b want 00 0 00", grant, busy, lat_err);
    end
    rst = 1'b0;
    tick(); tick();
    n_tests++; if (grant !== 2'b01) begin n_fail++; $display("FAIL rstmid_restart got %b want 01", grant); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_err_clr();
    do_reset();
    req = 2'b11;
    for (int i = 0; i < 6; i++) tick();
    n_tests++; if (lat_err !== 2'b10 || grant !== 2'b01) begin n_fail++; $display("FAIL clr_setup got e=%b g=%b want 10 01", lat_err, grant); end
    req = 2'b01; err_clr = 1'b1;
    tick();
    n_tests++; if (lat_err !== 2'b00) begin n_fail++; $display("FAIL clr_clear got %b want 00", lat_err); end
    err_clr = 1'b0; req = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    n_tests++; if (lat_err !== 2'b00) begin n_fail++; $display("FAIL clr_e12 got %b want 00", lat_err); end
    err_clr = 1'b1;
    tick(); // sixth ungranted edge coincides with clear
    n_tests++; if (lat_err !== 2'b10) begin n_fail++; $display("FAIL clr_setwins got %b want 10", lat_err); end
    err_clr = 1'b0; req = 2'b01;
    tick();
    n_tests++; if (lat_err !== 2'b10) begin n_fail++; $display("FAIL clr_sticky got %b want 10", lat_err); end
    err_clr = 1'b1;
    tick();
    n_tests++; if (lat_err !== 2'b00) begin n_fail++; $display("FAIL clr_final got %b want 00", lat_err); end
    err_clr = 1'b0; req = 2'b00;
    tick();
  endtask

  task automatic test_lat5();
    do_reset();
    req5 = 1'b1;
    tick();                       // e1: selection
    tick(); tick(); tick();       // e4
    n_tests++; if (grant5 !== 1'b0 || busy5 !== 1'b1) begin n_fail++; $display("FAIL lat5_e4 got g=%b b=%b want 0 1", grant5, busy5); end
    tick();                       // e5: grant sampled high at e6
    n_tests++; if (grant5 !== 1'b1) begin n_fail++; $display("FAIL lat5_grant got %b want 1", grant5); end
    tick(); tick();
    n_tests++; if (lat5 !== 1'b0 || grant5 !== 1'b1) begin n_fail++; $display("FAIL lat5_noerr got e=%b g=%b want 0 1", lat5, grant5); end
    req5 = 1'b0;
    tick();
    n_tests++; if (grant5 !== 1'b0 || busy5 !== 1'b0) begin n_fail++; $display("FAIL lat5_release got g=%b b=%b want 0 0", grant5, busy5); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_abandon();
    test_reset_mid();
    test_err_clr();
    test_lat5();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
